// File: rtl/mem_responder.sv
// Word-addressed memory responder with a linked free list threaded through
// the storage words. The list is rebuilt after every reset, and requests are
// serviced one at a time with a single-cycle mem_ready completion pulse.
module mem_responder #(
  parameter int unsigned addr_width = 10,
  parameter int unsigned data_width = 64,
  parameter int unsigned nil_addr   = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_execute,
  input  logic [1:0]            mem_func,
  input  logic [addr_width-1:0] address,
  input  logic [data_width-1:0] write_data,
  output logic                  mem_ready,
  output logic [data_width-1:0] read_data,
  output logic [addr_width-1:0] free_addr,
  output logic                  mem_error,
  output logic                  init_done,
  output logic [addr_width-1:0] free_count
);

  localparam int unsigned DEPTH = 1 << addr_width;
  localparam logic [addr_width-1:0] NIL      = addr_width'(nil_addr);
  localparam logic [addr_width-1:0] LAST_IDX = addr_width'(nil_addr - 1);
  localparam logic [addr_width-1:0] ONE      = addr_width'(1);
  localparam logic [addr_width-1:0] FULL     = '1;

  typedef enum logic [1:0] {
    F_GET_CONTENTS,
    F_SET_CONTENTS,
    F_GET_FREE,
    F_SET_FREE
  } func_e;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD,
    S_RD_RESP,
    S_WR,
    S_ALLOC,
    S_ALLOC_RESP,
    S_FREE
  } state_e;

  logic [data_width-1:0] mem [DEPTH];

  state_e                state;
  logic [addr_width-1:0] init_idx;
  logic [addr_width-1:0] init_link;
  logic [addr_width-1:0] head;
  logic [addr_width-1:0] addr_q;
  logic [data_width-1:0] wdata_q;
  logic [data_width-1:0] ram_q;

  logic                  ram_we;
  logic [addr_width-1:0] ram_waddr;
  logic [addr_width-1:0] ram_raddr;
  logic [data_width-1:0] ram_wdata;

  // RAM port control derived from the current state; writes are suppressed under reset.
  always_comb begin
    init_link = init_idx + ONE;
    ram_we    = 1'b0;
    ram_waddr = addr_q;
    ram_wdata = wdata_q;
    ram_raddr = addr_q;
    unique case (state)
      S_INIT: begin
        ram_we    = 1'b1;
        ram_waddr = init_idx;
        ram_wdata = data_width'(init_link);
      end
      S_WR: begin
        ram_we = 1'b1;
      end
      S_ALLOC: begin
        ram_raddr = head;
      end
      S_ALLOC_RESP: begin
        ram_we    = 1'b1;
        ram_waddr = head;
        ram_wdata = '0;
      end
      S_FREE: begin
        ram_we    = (addr_q != NIL);
        ram_wdata = data_width'(head);
      end
      default: ;
    endcase
    if (rst) ram_we = 1'b0;
  end

  // Storage array: one write port, registered read port.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_q <= mem[ram_raddr];
  end

  // Request sequencer with registered outputs; an empty-list GET_FREE still
  // passes through ALLOC so the error is reported one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      init_idx   <= '0;
      head       <= NIL;
      free_count <= '0;
      init_done  <= 1'b0;
      mem_ready  <= 1'b0;
      mem_error  <= 1'b0;
      read_data  <= '0;
      free_addr  <= NIL;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      mem_ready <= 1'b0;
      mem_error <= 1'b0;
      unique case (state)
        S_INIT: begin
          if (free_count != FULL) free_count <= free_count + ONE;
          init_idx <= init_link;
          if (init_idx == LAST_IDX) begin
            head      <= '0;
            init_done <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (mem_execute) begin
            addr_q  <= address;
            wdata_q <= write_data;
            unique case (func_e'(mem_func))
              F_GET_CONTENTS: state <= S_RD;
              F_SET_CONTENTS: state <= S_WR;
              F_GET_FREE:     state <= S_ALLOC;
              F_SET_FREE:     state <= S_FREE;
              default:        state <= S_IDLE;
            endcase
          end
        end
        S_RD: begin
          state <= S_RD_RESP;
        end
        S_RD_RESP: begin
          read_data <= ram_q;
          mem_ready <= 1'b1;
          state     <= S_IDLE;
        end
        S_WR: begin
          mem_ready <= 1'b1;
          state     <= S_IDLE;
        end
        S_ALLOC: begin
          if (head == NIL) begin
            free_addr <= NIL;
            mem_error <= 1'b1;
            mem_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            state <= S_ALLOC_RESP;
          end
        end
        S_ALLOC_RESP: begin
          free_addr <= head;
          head      <= ram_q[addr_width-1:0];
          if (free_count != '0) free_count <= free_count - ONE;
          mem_ready <= 1'b1;
          state     <= S_IDLE;
        end
        S_FREE: begin
          if (addr_q == NIL) begin
            mem_error <= 1'b1;
          end else begin
            head <= addr_q;
            if (free_count != FULL) free_count <= free_count + ONE;
          end
          mem_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter addr_width, default 10: word address width; 1024 words.
REQ-002 Parameter data_width, default 64: word width {tag[63:56], hed[55:28], tel[27:0]}.
REQ-003 Parameter nil_addr, default 1023: reserved NIL address; never stored, never allocated.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 mem_execute  input  1  one-cycle request strobe from initiator.
REQ-007 mem_func  input  2  0 GET_CONTENTS, 1 SET_CONTENTS, 2 GET_FREE, 3 SET_FREE.
REQ-008 address  input  addr_width  target word for GET/SET_CONTENTS and SET_FREE.
REQ-009 write_data  input  data_width  word for SET_CONTENTS.
REQ-010 mem_ready  output  1  one-cycle completion pulse.
REQ-011 read_data  output  data_width  GET_CONTENTS result; valid while mem_ready=1, held until next GET_CONTENTS completes.
REQ-012 free_addr  output  addr_width  GET_FREE result; valid while mem_ready=1, held until next GET_FREE completes.
REQ-013 mem_error  output  1  one-cycle pulse with mem_ready when the request failed.
REQ-014 init_done  output  1  high once free-list build is complete.
REQ-015 free_count  output  addr_width  number of words on the free list.

Function
REQ-016 Storage SHALL be an internal 1024 x data_width RAM with one-cycle synchronous read.
REQ-017 States: INIT, IDLE, RD, RD_RESP, WR, ALLOC, ALLOC_RESP, FREE.
REQ-018 INIT: each cycle writes mem[i] = {54'b0, i+1} for i = 0..1022, increments free_count; after i=1022, head := 0, init_done := 1, go IDLE.
REQ-019 Requests SHALL be accepted only in IDLE with mem_execute=1; mem_execute in any other state (including INIT) SHALL be ignored, not queued.
REQ-020 Acceptance cycle N latches mem_func, address, write_data.
REQ-021 GET_CONTENTS: N+1 RD issues RAM read; N+2 RD_RESP drives read_data = mem[address], mem_ready=1; back to IDLE.
REQ-022 SET_CONTENTS: N+1 WR writes mem[address]=write_data, mem_ready=1; back to IDLE.
REQ-023 GET_FREE, head != nil_addr: N+1 ALLOC reads mem[head]; N+2 ALLOC_RESP drives free_addr=head, head := mem[head][9:0], writes mem[old head]=0, free_count -1, mem_ready=1.
REQ-024 GET_FREE, head == nil_addr: N+1 drives free_addr=nil_addr, mem_error=1, mem_ready=1; head, free_count unchanged.
REQ-025 SET_FREE, address != nil_addr: N+1 FREE writes mem[address]={54'b0, head}, head := address, free_count +1, mem_ready=1.
REQ-026 SET_FREE of nil_addr: N+1 mem_ready=1, mem_error=1, no state change.
REQ-027 SET/GET_CONTENTS to nil_addr SHALL be performed normally (word exists, only excluded from allocation).
REQ-028 Double-free is not detected; free_count saturates at 1023 and does not wrap.
REQ-029 mem_ready and mem_error SHALL never be high for more than one consecutive cycle; next request may be accepted the cycle after mem_ready.
REQ-030 A request completing with mem_ready SHALL be followed by at least one IDLE cycle before the next mem_ready.

Reset
REQ-031 rst=1 at a clock edge SHALL: state := INIT, i := 0, head := nil_addr, free_count := 0, init_done := 0, mem_ready := 0, mem_error := 0, read_data := 0, free_addr := nil_addr.
REQ-032 Reset mid-operation SHALL abort the request with no mem_ready and rebuild the free list; RAM contents other than list links are not cleared.
REQ-033 Outputs SHALL hold reset values while rst=1.

Verification
REQ-034 Release rst at cycle 0 -> init_done=1 first seen at cycle 1023, free_count=1023; mem_execute at cycle 500 produces no mem_ready.
REQ-035 SET_CONTENTS addr 5 data 64'h8000_0000_1234_5678 -> mem_ready at N+1; then GET_CONTENTS addr 5 -> mem_ready at N+2, read_data=64'h8000_0000_1234_5678.
REQ-036 After init, three GET_FREE -> free_addr 0, 1, 2 with mem_ready at N+2 each; free_count=1020; GET_CONTENTS addr 1 returns 0.
REQ-037 SET_FREE addr 1 then GET_FREE -> free_addr=1, free_count restored; SET_FREE addr 1023 -> mem_ready with mem_error=1, free_count unchanged.
REQ-038 1023 GET_FREE then one more -> last returns free_addr=1023, mem_error=1 at N+1, free_count=0.
REQ-039 rst asserted the cycle after a GET_FREE is accepted -> no mem_ready, free_count=0; init_done rises 1023 cycles after release; first GET_FREE returns 0.
